fib_dispatch: RTL and testbench

FIB_DISPATCH -- requirements
Module: fib_dispatch

---
 rtl/fib_dispatch.sv | 208 ++++++++++++++++++++
 tb/tb_fib_dispatch.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_dispatch.sv
// fib_dispatch: request FIFO feeding a single-outstanding Fibonacci controller,
// with a held response port. Define FIB_TIMEOUT_EN to add a watchdog that ends a
// stalled controller handshake with an error response after TIMEOUT cycles.
module fib_dispatch #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned RW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [4:0]    req_i,
    output logic          fib_start,
    output logic [4:0]    fib_i,
    input  logic          fib_done,
    input  logic [RW-1:0] fib_result,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [RW-1:0] rsp_data,
    output logic [4:0]    rsp_i,
    output logic          rsp_err,
    output logic          busy
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {StHoldoff, StIdle, StIssue, StWait, StResp} state_e;

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_e        state_q, state_d;
    logic          hold_q, hold_d;
    logic [4:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop, full, empty;
    logic          fib_start_q, fib_start_d;
    logic [4:0]    fib_i_q, fib_i_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [RW-1:0] rsp_data_q, rsp_data_d;
    logic [4:0]    rsp_i_q, rsp_i_d;

    assign full      = (cnt_q == (AW + 1)'(DEPTH));
    assign empty     = (cnt_q == '0);
    // No bypass: a full FIFO refuses a push even when the FSM pops in the same cycle.
    assign req_ready = rst_n && !full;
    assign push      = req_valid && req_ready;
    assign busy      = rst_n && (!empty || (state_q != StIdle));

    assign fib_start = fib_start_q;
    assign fib_i     = fib_i_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_i     = rsp_i_q;

    // FIFO storage; validity is tracked by the count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= req_i;
        end
    end

    // FIFO occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (AW + 1)'(1);
        end
    end

    // FIFO pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

`ifdef FIB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout;
    logic          rsp_err_q, rsp_err_d;

    assign timeout = (to_cnt_q == TW'(TIMEOUT - 1));
    assign rsp_err = rsp_err_q;

    // Watchdog: cleared while issuing, counts each cycle spent waiting on the controller.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == StIssue) begin
            to_cnt_d = '0;
        end else if (state_q == StWait) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    // Next-state and registered-output logic of the dispatch FSM.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        pop         = 1'b0;
        fib_start_d = 1'b0;
        fib_i_d     = fib_i_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_i_d     = rsp_i_q;
`ifdef FIB_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif
        unique case (state_q)
            StHoldoff: begin
                hold_d = 1'b1;
                if (hold_q) state_d = StIdle;
            end
            StIdle: begin
                if (!empty) begin
                    pop         = 1'b1;
                    fib_i_d     = mem_q[rptr_q];
                    fib_start_d = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                // fib_done wins over a simultaneous timeout.
                if (fib_done) begin
                    rsp_data_d  = fib_result;
                    rsp_i_d     = fib_i_q;
                    rsp_valid_d = 1'b1;
`ifdef FIB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = StResp;
`ifdef FIB_TIMEOUT_EN
                end else if (timeout) begin
                    rsp_data_d  = '0;
                    rsp_i_d     = fib_i_q;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = StResp;
`endif
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StHoldoff;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHoldoff;
            hold_q      <= 1'b0;
            fib_start_q <= 1'b0;
            fib_i_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_i_q     <= '0;
`ifdef FIB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            fib_start_q <= fib_start_d;
            fib_i_q     <= fib_i_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_i_q     <= rsp_i_d;
`ifdef FIB_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_fib_dispatch.sv
// Self-checking bench for fib_dispatch with a behavioural Fibonacci controller
// and a scoreboard queue of expected responses.
module tb_fib_dispatch;
    localparam int unsigned RW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [4:0]    req_i = '0;
    logic          fib_start;
    logic [4:0]    fib_i;
    logic          fib_done = 1'b0;
    logic [RW-1:0] fib_result = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [RW-1:0] rsp_data;
    logic [4:0]    rsp_i;
    logic          rsp_err;
    logic          busy;

    always #5 clk = ~clk;

    fib_dispatch #(.DEPTH(4), .RW(RW), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_i(req_i), .fib_start(fib_start), .fib_i(fib_i), .fib_done(fib_done),
        .fib_result(fib_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_i(rsp_i), .rsp_err(rsp_err), .busy(busy)
    );

    typedef struct packed {
        logic [4:0]    idx;
        logic [RW-1:0] res;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         starts = 0;
    int         overlap_err = 0;
    bit         ctl_en = 1'b1;
    bit         ctl_busy = 1'b0;
    bit         ctl_clear = 1'b0;
    bit         manual_done = 1'b0;
    int         ctl_delay = 12;
    int         ctl_cnt = 0;
    logic [4:0] ctl_idx = '0;

    function automatic logic [RW-1:0] fib_ref(input logic [4:0] n);
        logic [RW-1:0] a, b, t;
        a = '0;
        b = RW'(1);
        for (int k = 0; k < int'(n); k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Controller model: answers ctl_delay cycles after fib_start, flags overlapping starts.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            fib_done = 1'b0;
            if (ctl_clear) begin
                ctl_busy  = 1'b0;
                ctl_clear = 1'b0;
            end
            if (manual_done) begin
                fib_done    = 1'b1;
                fib_result  = fib_ref(fib_i);
                manual_done = 1'b0;
                ctl_busy    = 1'b0;
            end else if (ctl_busy && ctl_en) begin
                if (ctl_cnt == 0) begin
                    fib_done   = 1'b1;
                    fib_result = fib_ref(ctl_idx);
                    ctl_busy   = 1'b0;
                end else begin
                    ctl_cnt--;
                end
            end
            if (fib_start === 1'b1) begin
                if (ctl_busy) overlap_err++;
                ctl_busy = 1'b1;
                ctl_idx  = fib_i;
                ctl_cnt  = ctl_delay - 1;
                starts++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang, want completion");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic push_req(input logic [4:0] idx, output bit ok);
        ok        = 1'b0;
        req_valid = 1'b1;
        req_i     = idx;
        for (int i = 0; i < 300; i++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) begin
            sb.push_back('{idx: idx, res: fib_ref(idx)});
            step();
        end
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [RW-1:0] d, output logic [4:0] ix, output logic e,
                           output bit ok);
        ok = 1'b0;
        d  = '0;
        ix = '0;
        e  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) begin
            d         = rsp_data;
            ix        = rsp_i;
            e         = rsp_err;
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({req_ready, busy, fib_start, rsp_valid, rsp_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got rdy/busy/start/valid/err=%b, want 00000",
                     {req_ready, busy, fib_start, rsp_valid, rsp_err});
        end
        n_cmp++;
        if (fib_i !== 5'd0 || rsp_data !== '0 || rsp_i !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_data: got fib_i=%0d rsp_data=%0d rsp_i=%0d, want 0 0 0",
                     fib_i, rsp_data, rsp_i);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b1 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL holdoff: got busy=%b ready=%b, want 1 1", busy, req_ready);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_holdoff: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_single();
        bit            ok, seen;
        logic [RW-1:0] d;
        logic [4:0]    ix;
        logic          e;
        exp_t          x;
        int            s0;
        s0        = starts;
        ctl_delay = 12;
        push_req(5'd10, ok);
        n_cmp++;
        if (!ok || fib_start !== 1'b0) begin
            n_bad++;
            $display("FAIL single_c1: got ok=%b start=%b, want 1 0", ok, fib_start);
        end
        step();
        n_cmp++;
        if (fib_start !== 1'b1 || fib_i !== 5'd10) begin
            n_bad++;
            $display("FAIL single_c2: got start=%b fib_i=%0d, want 1 10", fib_start, fib_i);
        end
        step();
        n_cmp++;
        if (fib_start !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pulse: got start=%b, want 0", fib_start);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (fib_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        n_cmp++;
        if (!seen || rsp_valid !== 1'b0 || fib_i !== 5'd10) begin
            n_bad++;
            $display("FAIL single_wait: got done=%b valid=%b fib_i=%0d, want 1 0 10",
                     seen, rsp_valid, fib_i);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_rsp_latency: got valid=%b, want 1", rsp_valid);
        end
        get_rsp(d, ix, e, ok);
        x = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++;
        if (!ok || d !== 32'd55 || ix !== 5'd10 || e !== 1'b0 || x.res !== 32'd55) begin
            n_bad++;
            $display("FAIL single_rsp: got ok=%b data=%0d idx=%0d err=%b, want 1 55 10 0",
                     ok, d, ix, e);
        end
        n_cmp++;
        if (starts - s0 != 1) begin
            n_bad++;
            $display("FAIL single_starts: got %0d, want 1", starts - s0);
        end
    endtask

    task automatic test_back_to_back();
        bit            ok, ok7;
        logic [RW-1:0] want [6];
        want = '{32'd2, 32'd0, 32'd1, 32'd5, 32'd6765, 32'd13};
        push_req(5'd3, ok);
        push_req(5'd0, ok);
        push_req(5'd1, ok);
        push_req(5'd5, ok);
        push_req(5'd20, ok);
        n_cmp++;
        if (!ok || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL burst_full: got ok=%b ready=%b, want 1 0", ok, req_ready);
        end
        ok7 = 1'b0;
        fork
            push_req(5'd7, ok7);
            begin
                logic [RW-1:0] d;
                logic [4:0]    ix;
                logic          e;
                bit            okr;
                exp_t          x;
                for (int i = 0; i < 6; i++) begin
                    get_rsp(d, ix, e, okr);
                    x = (sb.size() != 0) ? sb.pop_front() : '0;
                    n_cmp++;
                    if (!okr || d !== want[i] || ix !== x.idx || e !== 1'b0) begin
                        n_bad++;
                        $display("FAIL burst_rsp[%0d]: got ok=%b data=%0d idx=%0d err=%b, want 1 %0d %0d 0",
                                 i, okr, d, ix, e, want[i], x.idx);
                    end
                end
            end
        join
        n_cmp++;
        if (!ok7 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL burst_drain: got ok7=%b left=%0d, want 1 0", ok7, sb.size());
        end
    endtask

    task automatic test_backpressure();
        bit            ok;
        logic [4:0]    fill [5];
        logic [RW-1:0] d;
        logic [4:0]    ix;
        logic          e;
        exp_t          x;
        int            s0, k;
        fill = '{5'd2, 5'd3, 5'd4, 5'd6, 5'd8};
        push_req(5'd9, ok);
        for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd34) begin
            n_bad++;
            $display("FAIL bp_enter: got valid=%b data=%0d, want 1 34", rsp_valid, rsp_data);
        end
        s0 = starts;
        k  = 0;
        for (int c = 0; c < 20; c++) begin
            req_valid = 1'b1;
            req_i     = fill[k];
            if (req_ready === 1'b1 && k < 4) begin
                sb.push_back('{idx: fill[k], res: fib_ref(fill[k])});
                k++;
            end else if (req_ready === 1'b1) begin
                k++;
            end
            step();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd34 || rsp_i !== 5'd9) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%0d idx=%0d, want 1 34 9",
                         c, rsp_valid, rsp_data, rsp_i);
            end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (k != 4 || req_ready !== 1'b0 || starts != s0) begin
            n_bad++;
            $display("FAIL bp_fill: got accepted=%0d ready=%b starts=%0d, want 4 0 0",
                     k, req_ready, starts - s0);
        end
        for (int i = 0; i < 5; i++) begin
            get_rsp(d, ix, e, ok);
            x = (sb.size() != 0) ? sb.pop_front() : '0;
            n_cmp++;
            if (!ok || d !== x.res || ix !== x.idx || e !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_rsp[%0d]: got ok=%b data=%0d idx=%0d err=%b, want 1 %0d %0d 0",
                         i, ok, d, ix, e, x.res, x.idx);
            end
        end
    endtask

    task automatic test_push_pop_same_cycle();
        bit            ok;
        logic [RW-1:0] d;
        logic [4:0]    ix;
        logic          e;
        exp_t          x;
        push_req(5'd12, ok);
        for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) step();
        push_req(5'd13, ok);
        push_req(5'd14, ok);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                // FIFO holds two entries and the FSM is IDLE: push and pop coincide.
                n_cmp++;
                if (req_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL pp_pre: got ready=%b, want 1", req_ready);
                end
                push_req(5'd15, ok);
                n_cmp++;
                if (fib_start !== 1'b1 || fib_i !== 5'd13) begin
                    n_bad++;
                    $display("FAIL pp_issue: got start=%b fib_i=%0d, want 1 13", fib_start, fib_i);
                end
                push_req(5'd16, ok);
                n_cmp++;
                if (req_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL pp_cnt3: got ready=%b, want 1", req_ready);
                end
                push_req(5'd17, ok);
                n_cmp++;
                if (req_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL pp_cnt4: got ready=%b, want 0", req_ready);
                end
            end
            get_rsp(d, ix, e, ok);
            x = (sb.size() != 0) ? sb.pop_front() : '0;
            n_cmp++;
            if (!ok || d !== x.res || ix !== x.idx || e !== 1'b0) begin
                n_bad++;
                $display("FAIL pp_rsp[%0d]: got ok=%b data=%0d idx=%0d err=%b, want 1 %0d %0d 0",
                         i, ok, d, ix, e, x.res, x.idx);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok, any_valid;
        int s0;
        ctl_en = 1'b0;
        push_req(5'd15, ok);
        push_req(5'd16, ok);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, req_ready, busy, fib_start} !== 4'b0) begin
            n_bad++;
            $display("FAIL rst_wait_low: got valid/ready/busy/start=%b, want 0000",
                     {rsp_valid, req_ready, busy, fib_start});
        end
        ctl_clear = 1'b1;
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_wait_ready: got ready=%b, want 1", req_ready);
        end
        s0          = starts;
        manual_done = 1'b1;
        any_valid   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid !== 1'b0) any_valid = 1'b1;
        end
        n_cmp++;
        if (any_valid || starts != s0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wait_after: got valid_seen=%b starts=%0d busy=%b, want 0 0 0",
                     any_valid, starts - s0, busy);
        end
        ctl_en = 1'b1;
    endtask

`ifdef FIB_TIMEOUT_EN
    task automatic test_timeout();
        bit            ok, early;
        logic [RW-1:0] d;
        logic [4:0]    ix;
        logic          e;
        ctl_en = 1'b0;
        push_req(5'd11, ok);
        for (int i = 0; i < 10 && fib_start !== 1'b1; i++) step();
        early = 1'b0;
        for (int c = 0; c < 64; c++) begin
            step();
            if (rsp_valid !== 1'b0) early = 1'b1;
        end
        n_cmp++;
        if (early) begin
            n_bad++;
            $display("FAIL timeout_early: got valid before 64 WAIT cycles, want none");
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_edge: got valid=%b, want 1", rsp_valid);
        end
        get_rsp(d, ix, e, ok);
        void'(sb.pop_front());
        n_cmp++;
        if (!ok || d !== '0 || ix !== 5'd11 || e !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_rsp: got ok=%b data=%0d idx=%0d err=%b, want 1 0 11 1",
                     ok, d, ix, e);
        end
        ctl_clear = 1'b1;
        ctl_en    = 1'b1;
        step();
    endtask
`else
    task automatic test_no_timeout();
        bit            ok, early;
        logic [RW-1:0] d;
        logic [4:0]    ix;
        logic          e;
        exp_t          x;
        ctl_en = 1'b0;
        push_req(5'd19, ok);
        early = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) early = 1'b1;
        end
        n_cmp++;
        if (early) begin
            n_bad++;
            $display("FAIL no_timeout_wait: got response or err while controller silent, want none");
        end
        manual_done = 1'b1;
        get_rsp(d, ix, e, ok);
        x = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++;
        if (!ok || d !== 32'd4181 || ix !== x.idx || e !== 1'b0) begin
            n_bad++;
            $display("FAIL no_timeout_rsp: got ok=%b data=%0d idx=%0d err=%b, want 1 4181 19 0",
                     ok, d, ix, e);
        end
        ctl_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_push_pop_same_cycle();
        test_reset_mid_wait();
`ifdef FIB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        n_cmp++;
        if (overlap_err != 0) begin
            n_bad++;
            $display("FAIL single_outstanding: got %0d overlapping starts, want 0", overlap_err);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
